spi_reg_ctrl: RTL and testbench
===============================

// Module: spi_reg_ctrl
// PURPOSE
//  SPI-slave register controller for the iCE5 board. Synchronises the HW SPI pins into CLK25 and
//  decodes 16-bit frames into reads/writes of a small register file. The register file drives the
//  8 user LEDs and an 8-bit PWM generator for the RGB LED. Instantiated directly under the top
//  wrapper, between the HW_* SPI pins / SW inputs and the LED / RGB outputs.
// PARAMETERS
//  SYNC_STAGES  2      flops per SPI input synchroniser (>=2)
//  ID_VALUE     8'hA5  constant returned by the read-only ID register
//  LED_RESET    8'h00  reset value of the LED register
// PORTS
//  CLK25     in   1  system clock, 25 MHz
//  RST       in   1  synchronous reset, active-high
//  SPI_SS    in   1  slave select, active-low, asynchronous to CLK25
//  SPI_SCK   in   1  SPI clock, mode 0, f_SCK <= CLK25/8
//  SPI_MOSI  in   1  serial data in, MSB first
//  SPI_MISO  out  1  serial data out; 0 when not driving read data
//  SW        in   8  board switches, sampled into STATUS register
//  LED       out  8  LED register value
//  RGB_R     out  1  PWM output, red
//  RGB_G     out  1  PWM output, green
//  RGB_B     out  1  PWM output, blue
//  WR_STB    out  1  one-cycle pulse when a register write commits
//  WR_ADDR   out  3  address of the committed write, valid with WR_STB
// BEHAVIOUR
//  - Reset: LED=LED_RESET; DUTY_R/G/B=0; CTRL=0; SPI_MISO=0; RGB_*=0; WR_STB=0; WR_ADDR=0;
//    FSM=IDLE; bit counter=0; PWM counter=0.
//  - SS, SCK, MOSI each pass through SYNC_STAGES flops; SCK rise/fall detected on synced signals.
//  - Frame (16 bits, MSB first): [15]=W(1)/R(0), [14:8]=addr (only [10:8] decoded, [14:11] ignored),
//    [7:0]=write data (ignored on read). MOSI sampled on detected SCK rise.
//  - Register map: 0 LED (rw), 1 DUTY_R (rw), 2 DUTY_G (rw), 3 DUTY_B (rw), 4 CTRL (rw, bit0=PWM_EN,
//    bits[7:1] read 0), 5 STATUS (ro, SW synced by 2 flops), 6 ID (ro, ID_VALUE), 7 reserved (reads 0).
//  - FSM: IDLE -(SS low)-> ADDR; ADDR -(8th rise)-> DATA; DATA -(16th rise)-> DONE;
//    DONE holds until SS high. Synced SS high in any state -> IDLE, bit counter cleared.
//  - Write: at 16th rise with W=1 and addr in 0..4, register updates 1 CLK25 after the detected
//    edge; WR_STB pulses the same cycle with WR_ADDR=addr. Writes to 5,6,7 discarded, no WR_STB.
//  - Read: on 8th rise the addressed register is latched into the TX shifter (snapshot; later
//    changes do not affect the frame). On each SCK fall while in DATA, MISO = next bit, MSB first;
//    first fall after the 8th rise presents bit7. MISO=0 in IDLE, ADDR, DONE, and for write frames.
//  - Aborted frame (SS high before 16th rise): no write, no WR_STB, MISO returns to 0.
//  - Bits after the 16th while SS low: ignored; exactly one commit per frame.
//  - SPI write and RST in same cycle: RST wins. RST mid-frame: frame discarded; slave resyncs only
//    after SS goes high then low again.
//  - PWM: 8-bit free-running counter on CLK25, period 256 cycles.
//    RGB_x = PWM_EN & (cnt < DUTY_x), registered. DUTY=0 -> always 0; DUTY=255 -> high 255/256.
//    PWM_EN=0 -> all RGB outputs 0 next cycle. Duty changes take effect immediately (no double-buffer).
// TESTING
//  1. Write frame 0x8055 -> LED=0x55 after frame, WR_STB one pulse with WR_ADDR=0; regs 1..4 unchanged.
//  2. Read frame 0x0600 -> MISO returns 0xA5; read 0x0500 with SW=0x3C -> MISO returns 0x3C.
//  3. Write DUTY_R=0x40, CTRL=0x01 -> RGB_R high exactly 64 of every 256 CLK25 cycles; G/B stay 0.
//  4. Abort: SS high after 12 bits of 0x81FF -> DUTY_R unchanged, no WR_STB; next full frame works.
//  5. Writes 0x85AA / 0x86AA / 0x87AA -> no register change, no WR_STB; read of addr 7 returns 0x00.
//  6. RST asserted mid-frame during 0x80FF -> LED=0x00; frames accepted again after SS high->low.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//   SPI-slave (mode 0) register controller. The SPI pins are synchronised into
//   CLK25, 16-bit frames are decoded into reads and writes of a small register
//   file, and the register file drives the user LEDs and a 3-channel 8-bit PWM
//   generator for the RGB LED.
//
//   Frame, MSB first: [15] W(1)/R(0), [14:8] address (only [10:8] decoded),
//   [7:0] write data (ignored on reads).
//
//   Register map:
//     0 LED     rw
//     1 DUTY_R  rw
//     2 DUTY_G  rw
//     3 DUTY_B  rw
//     4 CTRL    rw  bit0 = PWM_EN, bits[7:1] read 0
//     5 STATUS  ro  synchronised SW
//     6 ID      ro  ID_VALUE
//     7 -       reads 0
//
// Ports
//   CLK25     in   system clock, 25 MHz
//   RST       in   synchronous reset, active-high
//   SPI_SS    in   slave select, active-low, asynchronous
//   SPI_SCK   in   SPI clock, mode 0, f_SCK <= CLK25/8
//   SPI_MOSI  in   serial data in, MSB first
//   SPI_MISO  out  serial read data, 0 when not returning read data
//   SW        in   board switches, visible through STATUS
//   LED       out  LED register
//   RGB_R/G/B out  registered PWM outputs
//   WR_STB    out  one-cycle pulse when a register write commits
//   WR_ADDR   out  address of the committed write, valid with WR_STB
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  ID_VALUE    = 8'hA5,
   parameter logic [7:0]  LED_RESET   = 8'h00
) (
   input  logic       CLK25,
   input  logic       RST,
   input  logic       SPI_SS,
   input  logic       SPI_SCK,
   input  logic       SPI_MOSI,
   output logic       SPI_MISO,
   input  logic [7:0] SW,
   output logic [7:0] LED,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B,
   output logic       WR_STB,
   output logic [2:0] WR_ADDR
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronisers
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sck_prev_q;
   logic [7:0]             sw_meta_q;
   logic [7:0]             sw_sync_q;

   logic ss_s;
   logic sck_s;
   logic mosi_s;
   logic sck_rise;
   logic sck_fall;

   // The SS chain resets to "selected" so that a frame already in progress
   // when reset releases is never picked up half-way; the slave only arms
   // once it has seen SS high.
   always_ff @(posedge CLK25) begin
      if (RST) begin
         ss_sync_q   <= '0;
         sck_sync_q  <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         sw_meta_q   <= '0;
         sw_sync_q   <= '0;
      end else begin
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0],   SPI_SS};
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  SPI_SCK};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
         sck_prev_q  <= sck_s;
         sw_meta_q   <= SW;
         sw_sync_q   <= sw_meta_q;
      end
   end

   assign ss_s     = ss_sync_q[SYNC_STAGES-1];
   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;

   // ---------------------------------------------------------------------------
   // Register file storage
   // ---------------------------------------------------------------------------
   logic [7:0] led_q;
   logic [7:0] duty_r_q;
   logic [7:0] duty_g_q;
   logic [7:0] duty_b_q;
   logic       pwm_en_q;

   // ---------------------------------------------------------------------------
   // Frame decoder state
   // ---------------------------------------------------------------------------
   state_t     state_q;
   logic [3:0] bit_cnt_q;
   logic [7:0] rx_q;
   logic [7:0] tx_q;
   logic       we_q;
   logic [2:0] addr_q;
   logic       armed_q;
   logic       miso_q;
   logic       wr_stb_q;
   logic [2:0] wr_addr_q;

   // Command byte fields as they complete on the 8th rise: the shifter holds
   // the first seven bits and the eighth is the bit being sampled now.
   logic       cmd_we;
   logic [2:0] cmd_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data_d;

   assign cmd_we   = rx_q[6];
   assign cmd_addr = {rx_q[1:0], mosi_s};
   assign wr_data  = {rx_q[6:0], mosi_s};

   always_comb begin
      rd_data_d = '0;
      case (cmd_addr)
         3'd0:    rd_data_d = led_q;
         3'd1:    rd_data_d = duty_r_q;
         3'd2:    rd_data_d = duty_g_q;
         3'd3:    rd_data_d = duty_b_q;
         3'd4:    rd_data_d = {7'b0, pwm_en_q};
         3'd5:    rd_data_d = sw_sync_q;
         3'd6:    rd_data_d = ID_VALUE;
         default: rd_data_d = '0;
      endcase
   end

   always_ff @(posedge CLK25) begin
      if (RST) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         rx_q      <= '0;
         tx_q      <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         armed_q   <= 1'b0;
         miso_q    <= 1'b0;
         wr_stb_q  <= 1'b0;
         wr_addr_q <= '0;
         led_q     <= LED_RESET;
         duty_r_q  <= '0;
         duty_g_q  <= '0;
         duty_b_q  <= '0;
         pwm_en_q  <= 1'b0;
      end else begin
         wr_stb_q <= 1'b0;

         if (ss_s) begin
            // Deselect ends or aborts any frame.
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            armed_q   <= 1'b1;
         end else begin
            case (state_q)
               S_IDLE: begin
                  miso_q    <= 1'b0;
                  bit_cnt_q <= '0;
                  if (armed_q) begin
                     state_q <= S_ADDR;
                  end
               end

               S_ADDR: begin
                  miso_q <= 1'b0;
                  if (sck_rise) begin
                     rx_q      <= {rx_q[6:0], mosi_s};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        state_q <= S_DATA;
                        we_q    <= cmd_we;
                        addr_q  <= cmd_addr;
                        // Read data is a snapshot taken here.
                        tx_q    <= cmd_we ? 8'h00 : rd_data_d;
                     end
                  end
               end

               S_DATA: begin
                  if (sck_fall) begin
                     miso_q <= tx_q[7];
                     tx_q   <= {tx_q[6:0], 1'b0};
                  end
                  if (sck_rise) begin
                     rx_q      <= {rx_q[6:0], mosi_s};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd15) begin
                        state_q <= S_DONE;
                        miso_q  <= 1'b0;
                        if (we_q && (addr_q <= 3'd4)) begin
                           wr_stb_q  <= 1'b1;
                           wr_addr_q <= addr_q;
                           case (addr_q)
                              3'd0:    led_q    <= wr_data;
                              3'd1:    duty_r_q <= wr_data;
                              3'd2:    duty_g_q <= wr_data;
                              3'd3:    duty_b_q <= wr_data;
                              default: pwm_en_q <= wr_data[0];
                           endcase
                        end
                     end
                  end
               end

               default: begin
                  // S_DONE: surplus SCK edges are ignored until deselect.
                  miso_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // PWM generator
   // ---------------------------------------------------------------------------
   logic [7:0] pwm_cnt_q;
   logic       rgb_r_q;
   logic       rgb_g_q;
   logic       rgb_b_q;

   always_ff @(posedge CLK25) begin
      if (RST) begin
         pwm_cnt_q <= '0;
         rgb_r_q   <= 1'b0;
         rgb_g_q   <= 1'b0;
         rgb_b_q   <= 1'b0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 8'd1;
         rgb_r_q   <= pwm_en_q & (pwm_cnt_q < duty_r_q);
         rgb_g_q   <= pwm_en_q & (pwm_cnt_q < duty_g_q);
         rgb_b_q   <= pwm_en_q & (pwm_cnt_q < duty_b_q);
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign SPI_MISO = miso_q;
   assign LED      = led_q;
   assign RGB_R    = rgb_r_q;
   assign RGB_G    = rgb_g_q;
   assign RGB_B    = rgb_b_q;
   assign WR_STB   = wr_stb_q;
   assign WR_ADDR  = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ss = 1'b1;
   logic       sck = 1'b0;
   logic       mosi = 1'b0;
   logic       miso;
   logic [7:0] sw = 8'h00;
   logic [7:0] led;
   logic       rgb_r, rgb_g, rgb_b;
   logic       wr_stb;
   logic [2:0] wr_addr;

   spi_reg_ctrl #(
      .SYNC_STAGES(2),
      .ID_VALUE   (8'hA5),
      .LED_RESET  (8'h00)
   ) dut (
      .CLK25   (clk),
      .RST     (rst),
      .SPI_SS  (ss),
      .SPI_SCK (sck),
      .SPI_MOSI(mosi),
      .SPI_MISO(miso),
      .SW      (sw),
      .LED     (led),
      .RGB_R   (rgb_r),
      .RGB_G   (rgb_g),
      .RGB_B   (rgb_b),
      .WR_STB  (wr_stb),
      .WR_ADDR (wr_addr)
   );

   always #20 clk = ~clk;

   int         n_chk = 0;
   int         n_bad = 0;
   int         stb_cnt = 0;
   logic [2:0] last_wr_addr = '0;
   logic [15:0] rx_bits;

   always @(negedge clk) begin
      if (wr_stb) begin
         stb_cnt      = stb_cnt + 1;
         last_wr_addr = wr_addr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic ss_low();
      ss = 1'b0;
      wait_clk(6);
   endtask

   task automatic ss_high();
      ss = 1'b1;
      wait_clk(8);
   endtask

   // Master side of mode 0: MOSI set while SCK low, MISO sampled at the rise.
   task automatic send_bits(input logic [15:0] frame, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         mosi = frame[i];
         wait_clk(6);
         rx_bits = {rx_bits[14:0], miso};
         sck = 1'b1;
         wait_clk(6);
         sck = 1'b0;
      end
   endtask

   task automatic xfer(input logic [15:0] frame);
      rx_bits = '0;
      ss_low();
      send_bits(frame, 15, 0);
      wait_clk(6);
      ss_high();
   endtask

   task automatic count_pwm(output int nr, output int ng, output int nb);
      nr = 0; ng = 0; nb = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         nr += int'(rgb_r);
         ng += int'(rgb_g);
         nb += int'(rgb_b);
      end
   endtask

   typedef struct {
      logic [15:0] frame;
      logic [7:0]  sw;
      int          exp_stb;
      logic [7:0]  exp_rd;
      logic [7:0]  exp_led;
   } vec_t;

   vec_t vecs[19];

   initial begin
      int s0, nr, ng, nb;

      vecs[0]  = '{16'h8055, 8'h00, 1, 8'h00, 8'h55};  // write LED
      vecs[1]  = '{16'h0100, 8'h00, 0, 8'h00, 8'h55};  // DUTY_R untouched
      vecs[2]  = '{16'h0200, 8'h00, 0, 8'h00, 8'h55};
      vecs[3]  = '{16'h0300, 8'h00, 0, 8'h00, 8'h55};
      vecs[4]  = '{16'h0400, 8'h00, 0, 8'h00, 8'h55};
      vecs[5]  = '{16'h0600, 8'h00, 0, 8'hA5, 8'h55};  // ID
      vecs[6]  = '{16'h0500, 8'h3C, 0, 8'h3C, 8'h55};  // STATUS
      vecs[7]  = '{16'h0000, 8'h3C, 0, 8'h55, 8'h55};  // read LED
      vecs[8]  = '{16'h85AA, 8'h3C, 0, 8'h00, 8'h55};  // ro / reserved writes
      vecs[9]  = '{16'h86AA, 8'h3C, 0, 8'h00, 8'h55};
      vecs[10] = '{16'h87AA, 8'h3C, 0, 8'h00, 8'h55};
      vecs[11] = '{16'h0700, 8'h3C, 0, 8'h00, 8'h55};
      vecs[12] = '{16'h0500, 8'hC3, 0, 8'hC3, 8'h55};
      vecs[13] = '{16'h0600, 8'hC3, 0, 8'hA5, 8'h55};
      vecs[14] = '{16'h8140, 8'hC3, 1, 8'h00, 8'h55};  // DUTY_R = 0x40
      vecs[15] = '{16'h0155, 8'hC3, 0, 8'h40, 8'h55};  // data byte ignored on read
      vecs[16] = '{16'h84FF, 8'hC3, 1, 8'h00, 8'h55};  // CTRL, only bit0 kept
      vecs[17] = '{16'h0400, 8'hC3, 0, 8'h01, 8'h55};
      vecs[18] = '{16'hF8AA, 8'hC3, 1, 8'h00, 8'hAA};  // addr[14:11] ignored

      wait_clk(4);
      chk("rst_led",     32'(led),     32'h00);
      chk("rst_miso",    32'(miso),    32'h0);
      chk("rst_rgb",     32'({rgb_r, rgb_g, rgb_b}), 32'h0);
      chk("rst_wr_stb",  32'(wr_stb),  32'h0);
      chk("rst_wr_addr", 32'(wr_addr), 32'h0);
      rst = 1'b0;
      wait_clk(8);

      for (int v = 0; v < 19; v++) begin
         sw = vecs[v].sw;
         wait_clk(4);
         s0 = stb_cnt;
         xfer(vecs[v].frame);
         chk($sformatf("vec%0d_rx", v),  32'(rx_bits), 32'({8'h00, vecs[v].exp_rd}));
         chk($sformatf("vec%0d_stb", v), 32'(stb_cnt - s0), 32'(vecs[v].exp_stb));
         chk($sformatf("vec%0d_led", v), 32'(led), 32'(vecs[v].exp_led));
         if (vecs[v].exp_stb != 0)
            chk($sformatf("vec%0d_wr_addr", v), 32'(last_wr_addr), 32'(vecs[v].frame[10:8]));
      end

      // PWM with DUTY_R=0x40, PWM_EN=1, G/B duty 0
      count_pwm(nr, ng, nb);
      chk("pwm_r_40", 32'(nr), 32'd64);
      chk("pwm_g_0",  32'(ng), 32'd0);
      chk("pwm_b_0",  32'(nb), 32'd0);

      // Abort after 12 bits
      s0 = stb_cnt;
      rx_bits = '0;
      ss_low();
      send_bits(16'h81FF, 15, 4);
      ss_high();
      chk("abort_stb",  32'(stb_cnt - s0), 32'd0);
      chk("abort_miso", 32'(miso), 32'h0);
      xfer(16'h0100);
      chk("abort_duty_r", 32'(rx_bits), 32'h0040);

      // Full-scale duty
      xfer(16'h81FF);
      count_pwm(nr, ng, nb);
      chk("pwm_r_ff", 32'(nr), 32'd255);

      // PWM disable
      xfer(16'h8400);
      wait_clk(2);
      count_pwm(nr, ng, nb);
      chk("pwm_off_r", 32'(nr), 32'd0);

      // Reset mid-frame: remaining bits must not resume the frame
      s0 = stb_cnt;
      rx_bits = '0;
      ss_low();
      send_bits(16'h80FF, 15, 6);
      rst = 1'b1;
      wait_clk(2);
      rst = 1'b0;
      send_bits(16'h80FF, 5, 0);
      wait_clk(6);
      chk("rst_mid_led", 32'(led), 32'h00);
      chk("rst_mid_stb", 32'(stb_cnt - s0), 32'd0);
      ss_high();
      s0 = stb_cnt;
      xfer(16'h8033);
      chk("resync_led", 32'(led), 32'h33);
      chk("resync_stb", 32'(stb_cnt - s0), 32'd1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
